// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the register-bank FSM state type.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  function automatic logic [31:0] expand_mask(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

endpackage

// File: rtl/ahb_lane_decode.sv
// Byte-lane decode: transfer size and low address bits to a 4-bit lane mask plus misalignment flag.
module ahb_lane_decode
  import ahb_lite_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] mask,
  output logic       misaligned
);

  // Halfword lanes ignore addr_lo[0], so a misaligned access still maps onto an aligned pair.
  always_comb begin
    mask       = 4'b1111;
    misaligned = 1'b0;
    case (hsize)
      HSIZE_BYTE: mask = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        mask       = addr_lo[1] ? 4'b1100 : 4'b0011;
        misaligned = addr_lo[0];
      end
      HSIZE_WORD: misaligned = (addr_lo != 2'b00);
      default: mask = 4'b1111;
    endcase
  end

endmodule

// File: rtl/ahb_lite_reg_bank.sv
// AHB-Lite slave with NUM_REGS byte-writable 32-bit registers and programmable wait states.
// Define AHB_REG_BANK_ERR_EN to answer out-of-range, oversize and misaligned accesses with ERROR.
module ahb_lite_reg_bank
  import ahb_lite_pkg::*;
#(
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] RESET_VAL   = 32'h0
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic                       HSEL,
  input  logic [31:0]                HADDR,
  input  logic [1:0]                 HTRANS,
  input  logic                       HWRITE,
  input  logic [2:0]                 HSIZE,
  input  logic [31:0]                HWDATA,
  input  logic                       HREADY,
  output logic                       HREADYOUT,
  output logic                       HRESP,
  output logic [31:0]                HRDATA,
  output logic [NUM_REGS*32-1:0]     regs_o,
  output logic [NUM_REGS-1:0]        wr_pulse_o
);

  localparam int         IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  logic [3:0]       lane_mask;
  logic             misaligned;
  logic             size_err;
  logic             out_of_range;
  logic             capture;
  logic             illegal;
  logic [IDX_W-1:0] addr_idx;

  state_t           state_reg;
  logic [3:0]       cnt_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             write_reg;
  logic [3:0]       mask_reg;
  logic             oob_reg;
  logic             hreadyout_reg;
  logic             hresp_reg;
  logic             wr_en;
  logic [31:0]      regs [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse_reg;

  ahb_lane_decode u_lane_decode (
    .hsize      (HSIZE),
    .addr_lo    (HADDR[1:0]),
    .mask       (lane_mask),
    .misaligned (misaligned)
  );

  assign capture  = HREADY & HSEL & (HTRANS != HTRANS_IDLE) & (HTRANS != HTRANS_BUSY);
  assign addr_idx = HADDR[2+IDX_W-1:2];
  assign size_err = (HSIZE > HSIZE_WORD);
  // Range is judged on the whole word address so accesses past the bank never alias onto it.
  assign out_of_range = (HADDR[31:2] >= 30'(NUM_REGS));

`ifdef AHB_REG_BANK_ERR_EN
  assign illegal = out_of_range | size_err | misaligned;
`else
  logic err_unused;
  assign err_unused = size_err | misaligned;
  assign illegal    = 1'b0;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      write_reg     <= 1'b0;
      mask_reg      <= '0;
      oob_reg       <= 1'b0;
      hreadyout_reg <= 1'b1;
      hresp_reg     <= HRESP_OKAY;
    end else begin
      case (state_reg)
        ST_WAIT: begin
          if (cnt_reg == 4'd0) begin
            state_reg     <= ST_DATA;
            hreadyout_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
`ifdef AHB_REG_BANK_ERR_EN
        ST_ERR1: begin
          state_reg     <= ST_ERR2;
          hreadyout_reg <= 1'b1;
          hresp_reg     <= HRESP_ERROR;
        end
`endif
        default: begin
          if (capture) begin
            idx_reg   <= addr_idx;
            write_reg <= HWRITE;
            mask_reg  <= lane_mask;
            oob_reg   <= out_of_range;
            if (illegal) begin
              state_reg     <= ST_ERR1;
              hreadyout_reg <= 1'b0;
              hresp_reg     <= HRESP_ERROR;
            end else if (WAIT_STATES > 0) begin
              state_reg     <= ST_WAIT;
              cnt_reg       <= WAIT_LOAD;
              hreadyout_reg <= 1'b0;
              hresp_reg     <= HRESP_OKAY;
            end else begin
              state_reg     <= ST_DATA;
              hreadyout_reg <= 1'b1;
              hresp_reg     <= HRESP_OKAY;
            end
          end else begin
            state_reg     <= ST_IDLE;
            hreadyout_reg <= 1'b1;
            hresp_reg     <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  // ST_DATA always lasts one cycle, so this is the closing edge of the write.
  assign wr_en = (state_reg == ST_DATA) && write_reg && !oob_reg;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
          regs[gi]         <= RESET_VAL;
          wr_pulse_reg[gi] <= 1'b0;
        end else begin
          wr_pulse_reg[gi] <= wr_en && (idx_reg == IDX_W'(gi));
          if (wr_en && (idx_reg == IDX_W'(gi))) begin
            regs[gi] <= (regs[gi] & ~expand_mask(mask_reg)) | (HWDATA & expand_mask(mask_reg));
          end
        end
      end
      assign regs_o[32*gi +: 32] = regs[gi];
    end
  endgenerate

  assign HREADYOUT  = hreadyout_reg;
  assign HRESP      = hresp_reg;
  assign HRDATA     = ((state_reg == ST_DATA) && !write_reg && !oob_reg) ? regs[idx_reg] : 32'h0;
  assign wr_pulse_o = wr_pulse_reg;

endmodule
